// File: rtl/mod997_pkg.sv
// Shared constants, state encoding and helpers for the mod-997 serial reducers.
package mod997_pkg;

  localparam logic [9:0] MOD_997 = 10'd997;
  localparam int         DIGIT_W = 6;
  localparam int         RES_W   = 10;
  localparam int         T_W     = RES_W + DIGIT_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } state_e;

  // MODULUS << k for k = 5..0, index k holds the k-th shifted modulus.
  localparam logic [5:0][T_W-1:0] MOD_SHL = {
    16'd31904, 16'd15952, 16'd7976, 16'd3988, 16'd1994, 16'd997
  };

  // Shifted-modulus table for an arbitrary modulus, used at elaboration time.
  function automatic logic [5:0][T_W-1:0] mod_shl_terms(input int m);
    logic [5:0][T_W-1:0] terms;
    for (int k = 0; k < 6; k++) begin
      terms[k] = T_W'(m << k);
    end
    return terms;
  endfunction

  // One restoring-reduction stage: subtract the term when it fits.
  function automatic logic [T_W-1:0] cond_sub(input logic [T_W-1:0] t,
                                              input logic [T_W-1:0] term);
    logic [T_W-1:0] r;
    if (t >= term) begin
      r = t - term;
    end else begin
      r = t;
    end
    return r;
  endfunction

endpackage

// File: rtl/mod997_horner_step.sv
// Single Horner step: next_acc = (acc*64 + digit) mod MODULUS, no multiplier or divider.
// The shifted input is at most (MODULUS-1)*64+63 < MODULUS*64, so six conditional
// subtractions of MODULUS<<5 .. MODULUS<<0 always leave a value below MODULUS.
module mod997_horner_step
  import mod997_pkg::*;
#(
  parameter logic [5:0][T_W-1:0] TERMS = MOD_SHL
) (
  input  logic [RES_W-1:0]   acc,
  input  logic [DIGIT_W-1:0] digit,
  output logic [RES_W-1:0]   next_acc
);

  logic [T_W-1:0] t_s;

  // Shift in the digit, then peel off shifted moduli from the largest down.
  always_comb begin
    t_s = {acc, digit};
    for (int k = 5; k >= 0; k--) begin
      t_s = cond_sub(t_s, TERMS[k]);
    end
    next_acc = t_s[RES_W-1:0];
  end

endmodule

// File: rtl/mod997_horner_accumulator.sv
// Streaming residue accumulator: folds 6-bit digits (MSD first) into a residue
// mod MODULUS, presenting one registered result per operand with valid/ready.
module mod997_horner_accumulator #(
  parameter int MODULUS = 997,
  parameter int DIGIT_W = mod997_pkg::DIGIT_W,
  parameter int RES_W   = mod997_pkg::RES_W,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DIGIT_W-1:0] in_digit,
  input  logic               in_first,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [RES_W-1:0]   out_residue,
  output logic [CNT_W-1:0]   out_ndigits,
  output logic               restart_err
);

  import mod997_pkg::*;

  localparam logic [5:0][T_W-1:0] TERMS_L = mod_shl_terms(MODULUS);
  localparam logic [CNT_W-1:0]    CNT_ONE = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0]    CNT_MAX = {CNT_W{1'b1}};

  state_e             state_q, state_d;
  logic [RES_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RES_W-1:0]   out_residue_q, out_residue_d;
  logic [CNT_W-1:0]   out_ndigits_q, out_ndigits_d;
  logic               out_valid_q, out_valid_d;
  logic               restart_err_q, restart_err_d;
  logic               in_ready_q, in_ready_d;

  logic               accept_s;
  logic               fresh_s;
  logic [RES_W-1:0]   step_base_s;
  logic [RES_W-1:0]   step_next_s;
  logic [CNT_W-1:0]   cnt_inc_s;
  logic [CNT_W-1:0]   cnt_new_s;

  assign accept_s = in_valid & in_ready_q;

  // Choose the Horner seed: a fresh operand starts from zero, otherwise continue.
  always_comb begin
    fresh_s = 1'b1;
    if (state_q == ACC) begin
      fresh_s = in_first;
    end else begin
      fresh_s = 1'b1;
    end
    if (fresh_s) begin
      step_base_s = '0;
    end else begin
      step_base_s = acc_q;
    end
  end

  // Saturating digit count for the beat being accepted.
  always_comb begin
    if (cnt_q == CNT_MAX) begin
      cnt_inc_s = cnt_q;
    end else begin
      cnt_inc_s = cnt_q + CNT_ONE;
    end
    if (fresh_s) begin
      cnt_new_s = CNT_ONE;
    end else begin
      cnt_new_s = cnt_inc_s;
    end
  end

  mod997_horner_step #(
    .TERMS (TERMS_L)
  ) u_step (
    .acc      (step_base_s),
    .digit    (in_digit),
    .next_acc (step_next_s)
  );

  // Next-state, datapath and output-register updates for the accumulator FSM.
  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    cnt_d         = cnt_q;
    out_residue_d = out_residue_q;
    out_ndigits_d = out_ndigits_q;
    out_valid_d   = out_valid_q;
    restart_err_d = 1'b0;
    case (state_q)
      IDLE, ACC: begin
        if (accept_s) begin
          acc_d = step_next_s;
          cnt_d = cnt_new_s;
          if ((state_q == ACC) && in_first) begin
            restart_err_d = 1'b1;
          end else begin
            restart_err_d = 1'b0;
          end
          if (in_last) begin
            state_d       = OUT;
            out_valid_d   = 1'b1;
            out_residue_d = step_next_s;
            out_ndigits_d = cnt_new_s;
          end else begin
            state_d = ACC;
          end
        end else begin
          state_d = state_q;
        end
      end
      OUT: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end else begin
          state_d = OUT;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
    in_ready_d = (state_d != OUT);
  end

  // State and register bank; reset drops any partial operand and pending result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      acc_q         <= '0;
      cnt_q         <= '0;
      out_residue_q <= '0;
      out_ndigits_q <= '0;
      out_valid_q   <= 1'b0;
      restart_err_q <= 1'b0;
      in_ready_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      out_residue_q <= out_residue_d;
      out_ndigits_q <= out_ndigits_d;
      out_valid_q   <= out_valid_d;
      restart_err_q <= restart_err_d;
      in_ready_q    <= in_ready_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_residue = out_residue_q;
  assign out_ndigits = out_ndigits_q;
  assign restart_err = restart_err_q;

endmodule

// File: doc/mod997_horner_accumulator.md
Name: mod997_horner_accumulator

Overview:
- Sequential residue accumulator for the mod-997 calculator.
- Consumes a wide binary operand as a stream of 6-bit digits, most significant digit first, and emits the operand's 10-bit residue mod 997.
- Evaluates by Horner's rule: acc = (acc*64 + digit) mod 997.
- Sits downstream of the operand-splitting logic as the consumer end of the 6-bit digit / 10-bit residue interface used by the per-digit LUT blocks.

Parameters:
- MODULUS, 997, odd modulus; must satisfy MODULUS*64 > (MODULUS-1)*64 + 63.
- DIGIT_W, 6, digit width in bits.
- RES_W, 10, residue width in bits, ceil(log2(MODULUS)).
- CNT_W, 8, width of the digit counter; the counter saturates at 2^CNT_W-1.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  digit beat valid.
- in_ready  out  1  accumulator can take a beat.
- in_digit  in  DIGIT_W  digit value, MSD first.
- in_first  in  1  first digit of an operand.
- in_last  in  1  last digit of an operand.
- out_valid  out  1  residue available.
- out_ready  in  1  downstream accepts the residue.
- out_residue  out  RES_W  operand mod MODULUS, always < MODULUS.
- out_ndigits  out  CNT_W  number of digits folded into out_residue (saturating).
- restart_err  out  1  one-cycle pulse: a partial operand was discarded by in_first.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, acc=0, cnt=0.
  - in_ready=0 while rst_n is low.
  - out_valid=0, out_residue=0, out_ndigits=0, restart_err=0.
  - Reset mid-operand discards the partial operand and any pending output.
- States:
  - IDLE: in_ready=1. An accepted beat (in_valid&in_ready) loads acc=step(0,digit) and cnt=1, regardless of in_first. Next state is ACC, or OUT if in_last.
  - ACC: in_ready=1. An accepted beat with in_first=0 gives acc=step(acc,digit), cnt=sat(cnt+1). An accepted beat with in_first=1 gives acc=step(0,digit), cnt=1, and pulses restart_err for one cycle. If the beat has in_last, next state is OUT.
  - OUT: out_valid=1 and in_ready=0. out_residue and out_ndigits are registered and hold stable until out_ready. When out_valid&out_ready, next state is IDLE.
- Step function: step(a,d) = (a*64 + d) mod MODULUS.
  - Combinational, single cycle.
  - Form t=(a<<6)|d (16 bits, max 63807).
  - Conditionally subtract MODULUS<<k for k=5,4,3,2,1,0 in that order; subtract whenever t >= the term.
  - Result is guaranteed < MODULUS. No division and no multiplier.
- Timing and throughput:
  - Throughput: 1 digit per cycle while accumulating.
  - Latency: out_valid rises on the cycle after the in_last beat is accepted.
  - Minimum operand-to-operand gap: 1 cycle (OUT→IDLE). No result skid buffer.
- Boundaries:
  - A single-digit operand has in_first=in_last=1 on the same beat; the result is the digit itself.
  - in_digit, in_first and in_last are ignored when in_valid=0.
  - cnt saturates at 2^CNT_W-1. The residue remains correct beyond saturation.
  - out_ready held high while not in OUT has no effect.
  - in_valid asserted during OUT is stalled (in_ready=0), and the beat is not lost.
  - Only acc is updated by the datapath; the output registers update solely on the ACC/IDLE→OUT transition.

Decomposition:
- Shared package mod997_pkg holds:
  - MOD_997 = 10'd997
  - DIGIT_W, RES_W
  - state enum {IDLE, ACC, OUT}
  - the precomputed constants MODULUS<<k for k=0..5
- One combinational sub-module, mod997_horner_step:
  - inputs: acc (RES_W), digit (DIGIT_W); output: next_acc (RES_W).
  - Reused by the calculator's other serial reducers.
  - Verified exhaustively on its own: 997*64 = 63808 input combinations.

Test Plan:
- Single digit: in_first=in_last=1, digit=63 → out_residue=63, out_ndigits=1, out_valid one cycle after the beat.
- Two digits 15, 40 (operand 1000) → out_residue=3, out_ndigits=2.
- Three digits 63, 63, 63 (operand 262143):
  - intermediate acc values are 63, then 107.
  - final out_residue=929.
- Backpressure:
  - Complete operand 15, 40 with out_ready=0 for 5 cycles while in_valid=1 with the next digit 7.
  - Required: in_ready=0 and out_residue holds 3 throughout.
  - On out_ready=1, the next operand's first digit 7 is accepted the following cycle.
- Restart:
  - Send 15 (first), then 20 (first), then 40 (last).
  - Required: restart_err pulses once, out_residue=(20*64+40) mod 997 = 323, out_ndigits=2.
- Reset mid-operand:
  - Assert rst_n=0 asynchronously after digit 15.
  - Required: out_valid=0 and out_residue=0 immediately.
  - After release, the operand 0, 5 yields out_residue=5.
